power_engine_scheduler: RTL
===========================

Name: power_engine_scheduler

Overview:
- Shares one iterative power engine (result = base^exp, truncated to WIDTH bits) between N_REQ requesters.
- Round-robin arbitration on a valid/ready request interface.
- Internal square-and-multiply FSM time-shares a single WIDTH×WIDTH multiplier.
- Returns each result, requester id and an overflow flag on a valid/ready response interface. One operation in flight at a time.

Parameters:
WIDTH, 32, operand/result width in bits
EXP_W, 8, exponent width in bits
N_REQ, 4, number of requesters (2..16); ID_W = max(1, clog2(N_REQ)) is a derived localparam

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester accept, one-hot or zero
req_base  input  N_REQ*WIDTH  packed bases, requester k at [k*WIDTH +: WIDTH]
req_exp  input  N_REQ*EXP_W  packed exponents, requester k at [k*EXP_W +: EXP_W]
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
resp_id  output  ID_W  index of requester that issued the result
resp_data  output  WIDTH  base^exp mod 2^WIDTH
resp_overflow  output  1  true result exceeded WIDTH bits
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (reset low, asynchronous):
  - FSM to IDLE; rr_ptr=0; acc, b, e cleared.
  - resp_valid=0, resp_id=0, resp_data=0, resp_overflow=0, busy=0, req_ready=0.
  - Reset mid-operation discards the operation with no response. The first cycle after release is IDLE.
- Arbitration (IDLE only):
  - grant = first k with req_valid[k]=1, searching rr_ptr, rr_ptr+1, … mod N_REQ.
  - req_ready[grant]=1 combinationally in that cycle; all other req_ready bits are 0. req_ready is all zero outside IDLE.
  - On that edge: capture b=base[grant], e=exp[grant], id=grant; set acc=1, ovf=0; go to EVAL.
  - Requesters hold valid and data stable until ready.
  - rr_ptr becomes (grant+1) mod N_REQ when the request is accepted.
- States and transitions:
  - IDLE: arbitrate as above. With no valid request, stay in IDLE.
  - EVAL: e==0 goes to DONE; e[0]==1 goes to MUL; otherwise goes to SQR.
  - MUL: acc <= low WIDTH bits of acc*b. If the high half of the product is nonzero, set ovf. Go to SQR.
  - SQR: b <= low WIDTH bits of b*b; e <= e>>1. Set ovf only if the high half is nonzero AND (e>>1)!=0, so an unused final square never flags overflow. Go to EVAL.
  - DONE: resp_valid=1 with resp_data=acc, resp_id=id, resp_overflow=ovf. On resp_valid&&resp_ready, go to IDLE.
- One multiplier instance only; the MUL and SQR states use it in different cycles.
- Latency from the accept edge to resp_valid high is 2 + 2L + P cycles. L = bit length of exp (0 for exp=0); P = popcount(exp).
- Back-pressure: while resp_ready=0, DONE holds and all resp_* outputs stay stable. No new request is accepted. The next accept happens in the first IDLE cycle after the response handshake, so there is 1 idle-cycle minimum between operations.
- Edge cases:
  - exp=0 returns 1 with overflow 0, including base=0 (0^0=1).
  - base=0 with exp>0 returns 0; base=1 returns 1. Neither flags overflow.
  - busy=1 in every state except IDLE.

Test Plan:
- Single request, requester 0: base=3, exp=5 accepted at cycle 0 -> resp_valid at cycle 10, resp_data=243, resp_id=0, resp_overflow=0.
- exp=0: requester 2 sends base=0, exp=0 -> resp_valid 2 cycles after accept, resp_data=1, resp_overflow=0.
- Overflow, WIDTH=32: base=2, exp=32 -> resp_data=0, resp_overflow=1. Also base=2, exp=31 -> resp_data=0x80000000, resp_overflow=0. Also base=65536, exp=2 -> 0 with overflow=1.
- Round-robin fairness: all four req_valid held high with distinct operands, resp_ready=1 -> grant order 0,1,2,3,0. Each resp_id matches its operands' expected result. Exactly one req_ready bit high per accept.
- Back-pressure: resp_ready=0 for 5 cycles in DONE -> resp_* stable, req_ready stays 0, busy=1. Raising resp_ready completes the handshake, and the next request is accepted in the following cycle.
- Reset mid-operation: assert reset during MUL of base=3, exp=200 -> outputs clear immediately without a clock edge, and no response is issued. After release with requester 1 pending, grant=1 (rr_ptr=0 scan) and a correct result is returned.

Source files
------------

// File: rtl/power_engine_scheduler.sv
// Round-robin shared power engine: base^exp mod 2^WIDTH via square-and-multiply
// on a single time-shared multiplier, with per-result overflow detection.
module power_engine_scheduler #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned EXP_W = 8,
  parameter int unsigned N_REQ = 4,
  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_base,
  input  logic [N_REQ*EXP_W-1:0] req_exp,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [WIDTH-1:0]       resp_data,
  output logic                   resp_overflow,
  output logic                   busy
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_EVAL, S_MUL, S_SQR, S_DONE} state_t;

  state_t           r_state;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_id;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_b;
  logic [EXP_W-1:0] r_e;
  logic             r_ovf;

  logic [N_REQ-1:0] w_mask;
  logic [N_REQ-1:0] w_hi;
  logic [ID_W-1:0]  w_grant;
  logic             w_grant_vld;
  logic [WIDTH-1:0] w_base;
  logic [EXP_W-1:0] w_exp;
  logic [WIDTH-1:0] w_mul_a;
  logic [PW-1:0]    w_prod;
  logic             w_prod_hi;
  logic [EXP_W-1:0] w_e_shr;

  // Round-robin: lowest valid at or above rr_ptr, else lowest valid overall
  assign w_mask = ~((N_REQ'(1) << r_rr_ptr) - N_REQ'(1));
  assign w_hi   = req_valid & w_mask;

  always_comb begin
    w_grant     = '0;
    w_grant_vld = |req_valid;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) w_grant = ID_W'(i);
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_hi[i]) w_grant = ID_W'(i);
    end
  end

  always_comb begin
    w_base = '0;
    w_exp  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant == ID_W'(i)) begin
        w_base = req_base[i*WIDTH +: WIDTH];
        w_exp  = req_exp[i*EXP_W +: EXP_W];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset && r_state == S_IDLE && w_grant_vld) req_ready = N_REQ'(1) << w_grant;
  end

  // Single multiplier: acc*b in MUL, b*b in SQR
  assign w_mul_a   = (r_state == S_MUL) ? r_acc : r_b;
  assign w_prod    = PW'(w_mul_a) * PW'(r_b);
  assign w_prod_hi = |w_prod[PW-1:WIDTH];
  assign w_e_shr   = r_e >> 1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_e      <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_b      <= w_base;
            r_e      <= w_exp;
            r_id     <= w_grant;
            r_acc    <= WIDTH'(1);
            r_ovf    <= 1'b0;
            r_rr_ptr <= (w_grant == ID_W'(N_REQ - 1)) ? '0 : w_grant + ID_W'(1);
            r_state  <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (r_e == '0)    r_state <= S_DONE;
          else if (r_e[0])  r_state <= S_MUL;
          else              r_state <= S_SQR;
        end
        S_MUL: begin
          r_acc <= w_prod[WIDTH-1:0];
          if (w_prod_hi) r_ovf <= 1'b1;
          r_state <= S_SQR;
        end
        S_SQR: begin
          r_b <= w_prod[WIDTH-1:0];
          r_e <= w_e_shr;
          // A square whose result is never used must not flag overflow
          if (w_prod_hi && (w_e_shr != '0)) r_ovf <= 1'b1;
          r_state <= S_EVAL;
        end
        S_DONE: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid    = (r_state == S_DONE);
  assign resp_data     = r_acc;
  assign resp_id       = r_id;
  assign resp_overflow = r_ovf;
  assign busy          = (r_state != S_IDLE);

endmodule
